dff_pipe: RTL and testbench
===========================

// Module: dff_pipe
//
// PURPOSE
//   Parametrised register pipeline: DEPTH stages of WIDTH-bit flops, each with a valid bit.
//   Valid/ready handshake on both sides; bubbles collapse so gaps in the input stream do not stall it.
//   Adds back-pressure, flush, a reset value and an occupancy count on top of a single D flop.
//   Used as a retiming/delay stage between datapath blocks.
//
// PARAMETERS
//   WIDTH      8    data width in bits (>=1)
//   DEPTH      3    number of register stages (>=1)
//   RESET_VAL  '0   value loaded into every data stage on reset (WIDTH bits)
//
// PORTS
//   clk          in   1               rising-edge clock
//   reset        in   1               synchronous, active-high reset
//   flush_i      in   1               synchronous flush: drop all in-flight beats
//   in_valid_i   in   1               upstream beat valid
//   in_ready_o   out  1               pipe accepts a beat this cycle
//   in_data_i    in   WIDTH           upstream data
//   out_valid_o  out  1               stage DEPTH-1 holds a valid beat
//   out_ready_i  in   1               downstream accepts a beat
//   out_data_o   out  WIDTH           stage DEPTH-1 data
//   count_o      out  $clog2(DEPTH+1) number of valid stages (0..DEPTH)
//
// BEHAVIOUR
//   - Stage state: v[i], d[i], i = 0..DEPTH-1. Stage DEPTH-1 drives out_valid_o/out_data_o.
//   - Ready chain (combinational): rdy[DEPTH-1] = !v[DEPTH-1] | out_ready_i;
//     rdy[i] = !v[i] | rdy[i+1].
//   - in_ready_o = rdy[0] & !flush_i.
//   - Per clock, when rdy[i]: v[i] <= upstream valid, where upstream is in_valid_i & in_ready_o for i=0
//     and v[i-1] for i>0. d[i] <= upstream data only if upstream valid; otherwise d[i] holds.
//   - When !rdy[i]: v[i] and d[i] hold (stall). No beat is ever dropped or duplicated
//     except by flush or reset.
//   - Transfer in: in_valid_i & in_ready_o. Transfer out: out_valid_o & out_ready_i.
//   - Latency with an empty pipe and out_ready_i=1: DEPTH cycles from accept to out_valid_o.
//   - Throughput: 1 beat/cycle sustained while out_ready_i=1.
//   - count_o: registered. count <= count + in_xfer - out_xfer. Equals popcount(v) at all times.
//   - Flush (flush_i=1, reset=0): all v[i] <= 0 and count_o <= 0 next cycle. d[i] hold.
//     in_ready_o=0, so no input beat is accepted. An out_xfer in the flush cycle still counts
//     as delivered to downstream.
//   - Reset (priority over flush and handshake): v[i] <= 0, d[i] <= RESET_VAL, count_o <= 0.
//     Outputs after reset: out_valid_o=0, out_data_o=RESET_VAL, count_o=0,
//     in_ready_o=1 (when flush_i=0).
//     Reset mid-stream discards every in-flight beat.
//   - Full (count_o==DEPTH) & out_ready_i=0: in_ready_o=0.
//     Full & out_ready_i=1: simultaneous in and out transfer, count unchanged.
//   - DEPTH=1: a single handshaked register; rdy[0] = !v[0] | out_ready_i.
//   - out_data_o is undefined-but-stable while out_valid_o=0 (holds last value); benches must not check it.
//
// TESTING
//   1. Reset: assert reset 2 cycles with WIDTH=8, RESET_VAL=8'hA5 -> out_valid_o=0,
//      out_data_o=8'hA5, count_o=0, in_ready_o=1.
//   2. Latency/stream: DEPTH=3, out_ready_i=1, push 0x01..0x10 back-to-back -> 0x01 appears
//      3 cycles after accept, then one beat per cycle in order; in_ready_o stays 1.
//   3. Back-pressure: out_ready_i=0, push 5 beats -> 3 accepted, count_o=3, in_ready_o=0.
//      Then raise out_ready_i -> beats emerge in order, no loss or duplicates.
//   4. Bubble collapse: out_ready_i=0, v pattern {1,0,1} (one gap) -> in_ready_o=1,
//      next beat fills the gap; count_o goes 2->3.
//   5. Flush: pipe full, pulse flush_i with in_valid_i=1 -> in_ready_o=0 that cycle;
//      next cycle count_o=0, out_valid_o=0; no input beat enters.
//   6. Reset mid-operation: reset while count_o=2 and in/out handshakes active -> next cycle
//      all valids 0, out_data_o=RESET_VAL, count_o=0. No stale beat emerges afterward.

Source files
------------

// File: rtl/dff_pipe.sv
// rtl/dff_pipe.sv - valid/ready register pipeline with bubble collapse, flush and occupancy count
module dff_pipe #(
  parameter int              WIDTH     = 8,
  parameter int              DEPTH     = 3,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  localparam int             CW        = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o,
  output logic [CW-1:0]    count_o
);

  logic [DEPTH-1:0] v;
  logic [WIDTH-1:0] d    [DEPTH];
  logic [DEPTH-1:0] rdy;
  logic [DEPTH-1:0] up_v;
  logic [WIDTH-1:0] up_d [DEPTH];
  logic             full_tail;
  logic             in_xfer;
  logic             out_xfer;
  logic [CW-1:0]    count_q;

  // A stage can advance unless it and every stage downstream of it are full
  // while the sink stalls; unrolled as a suffix-AND to keep the chain acyclic.
  always_comb begin
    full_tail = 1'b1;
    rdy       = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      full_tail = full_tail & v[i];
      rdy[i]    = out_ready_i | ~full_tail;
    end
  end

  assign in_ready_o  = rdy[0] & ~flush_i;
  assign in_xfer     = in_valid_i & in_ready_o;
  assign out_valid_o = v[DEPTH-1];
  assign out_data_o  = d[DEPTH-1];
  assign out_xfer    = out_valid_o & out_ready_i;
  assign count_o     = count_q;

  always_comb begin
    up_v = '0;
    for (int i = 0; i < DEPTH; i++) begin
      up_d[i] = '0;
    end
    up_v[0] = in_xfer;
    up_d[0] = in_data_i;
    for (int i = 1; i < DEPTH; i++) begin
      up_v[i] = v[i-1];
      up_d[i] = d[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      v       <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        d[i] <= RESET_VAL;
      end
    end else if (flush_i) begin
      // Data registers keep their contents; only the valids are cleared.
      v       <= '0;
      count_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (rdy[i]) begin
          v[i] <= up_v[i];
          if (up_v[i]) begin
            d[i] <= up_d[i];
          end
        end
      end
      count_q <= count_q + CW'(in_xfer) - CW'(out_xfer);
    end
  end

endmodule

// File: tb/tb_dff_pipe.sv
// tb/tb_dff_pipe.sv - directed self-checking bench for dff_pipe (WIDTH=8, DEPTH=3, RESET_VAL=A5)
module tb_dff_pipe;

  logic       clk = 1'b0;
  logic       reset;
  logic       flush_i;
  logic       in_valid_i;
  logic       in_ready_o;
  logic [7:0] in_data_i;
  logic       out_valid_o;
  logic       out_ready_i;
  logic [7:0] out_data_o;
  logic [1:0] count_o;

  int n_asserts = 0;
  int n_fail    = 0;
  int sent;

  dff_pipe #(.WIDTH(8), .DEPTH(3), .RESET_VAL(8'hA5)) dut (
    .clk        (clk),
    .reset      (reset),
    .flush_i    (flush_i),
    .in_valid_i (in_valid_i),
    .in_ready_o (in_ready_o),
    .in_data_i  (in_data_i),
    .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i),
    .out_data_o (out_data_o),
    .count_o    (count_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    reset = 1'b1; flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b0; in_data_i = 8'h00;

    // reset for two cycles
    tick(); tick();
    reset = 1'b0;
    settle();
    chk("rst_out_valid", 32'(out_valid_o), 32'd0);
    chk("rst_out_data",  32'(out_data_o),  32'hA5);
    chk("rst_count",     32'(count_o),     32'd0);
    chk("rst_in_ready",  32'(in_ready_o),  32'd1);

    // latency and streaming: beat n leaves 3 cycles after acceptance
    out_ready_i = 1'b1;
    for (int n = 1; n <= 19; n++) begin
      in_valid_i = (n <= 16);
      in_data_i  = 8'(n);
      settle();
      if (n <= 16) chk("str_in_ready", 32'(in_ready_o), 32'd1);
      if (n >= 4) begin
        chk("str_out_valid", 32'(out_valid_o), 32'd1);
        chk("str_out_data",  32'(out_data_o),  32'(n - 3));
      end else begin
        chk("str_lat_valid", 32'(out_valid_o), 32'd0);
      end
      if (n == 4) chk("str_count", 32'(count_o), 32'd3);
      tick();
    end
    in_valid_i = 1'b0;
    settle();
    chk("str_end_count", 32'(count_o),     32'd0);
    chk("str_end_valid", 32'(out_valid_o), 32'd0);

    // back-pressure: five offers into a stalled pipe, only three fit
    out_ready_i = 1'b0;
    sent = 0;
    for (int k = 0; k < 5; k++) begin
      in_valid_i = 1'b1;
      in_data_i  = 8'(8'h21 + sent);
      settle();
      chk("bp_in_ready", 32'(in_ready_o), 32'(k < 3));
      if (in_ready_o) sent++;
      tick();
    end
    settle();
    chk("bp_count",     32'(count_o),     32'd3);
    chk("bp_in_ready2", 32'(in_ready_o),  32'd0);
    chk("bp_out_valid", 32'(out_valid_o), 32'd1);
    in_valid_i  = 1'b0;
    out_ready_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      settle();
      chk("bp_drain_valid", 32'(out_valid_o), 32'd1);
      chk("bp_drain_data",  32'(out_data_o),  32'(8'h21 + k));
      tick();
    end
    chk("bp_empty_valid", 32'(out_valid_o), 32'd0);
    chk("bp_empty_count", 32'(count_o),     32'd0);

    // bubble collapse: build v = {1,0,1} under stall, then fill the gap
    out_ready_i = 1'b0;
    in_valid_i = 1'b1; in_data_i = 8'h31; tick();
    chk("bub_count1", 32'(count_o), 32'd1);
    in_valid_i = 1'b0; tick();
    chk("bub_count2", 32'(count_o), 32'd1);
    in_valid_i = 1'b1; in_data_i = 8'h32; tick();
    chk("bub_count3", 32'(count_o), 32'd2);
    in_data_i = 8'h33;
    settle();
    chk("bub_in_ready", 32'(in_ready_o), 32'd1);
    tick();
    chk("bub_count4",   32'(count_o),    32'd3);
    chk("bub_full_rdy", 32'(in_ready_o), 32'd0);
    in_valid_i  = 1'b0;
    out_ready_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      settle();
      chk("bub_drain_valid", 32'(out_valid_o), 32'd1);
      chk("bub_drain_data",  32'(out_data_o),  32'(8'h31 + k));
      tick();
    end
    chk("bub_empty_valid", 32'(out_valid_o), 32'd0);

    // flush a full pipe while an input beat is offered
    out_ready_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_valid_i = 1'b1; in_data_i = 8'(8'h41 + k); tick();
    end
    chk("fl_full_count", 32'(count_o), 32'd3);
    flush_i = 1'b1; in_data_i = 8'h44;
    settle();
    chk("fl_in_ready", 32'(in_ready_o), 32'd0);
    tick();
    flush_i = 1'b0; in_valid_i = 1'b0;
    settle();
    chk("fl_count",     32'(count_o),     32'd0);
    chk("fl_out_valid", 32'(out_valid_o), 32'd0);
    chk("fl_in_ready2", 32'(in_ready_o),  32'd1);
    out_ready_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("fl_no_leak", 32'(out_valid_o), 32'd0);
    end

    // reset mid-stream with count 2 and both handshakes active
    in_valid_i = 1'b1; in_data_i = 8'h51; tick();
    in_data_i = 8'h52; tick();
    in_valid_i = 1'b0; tick();
    chk("mr_count", 32'(count_o),     32'd2);
    chk("mr_valid", 32'(out_valid_o), 32'd1);
    in_valid_i = 1'b1; in_data_i = 8'h53; reset = 1'b1;
    tick();
    reset = 1'b0; in_valid_i = 1'b0;
    settle();
    chk("mr_out_valid", 32'(out_valid_o), 32'd0);
    chk("mr_out_data",  32'(out_data_o),  32'hA5);
    chk("mr_count0",    32'(count_o),     32'd0);
    chk("mr_in_ready",  32'(in_ready_o),  32'd1);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("mr_no_stale", 32'(out_valid_o), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
